// File: rtl/tcdm_bram_pipe_bridge.sv
// Bridges a req/gnt/r_valid memory port to a native single-port BRAM: zero-fills the BRAM after reset,
// tracks the read latency and rejects out-of-range accesses. Optional counters: `define TCDM_BRIDGE_STATS_EN.
module tcdm_bram_pipe_bridge #(
  parameter int                    ADDR_WIDTH  = 10,
  parameter int                    DATA_WIDTH  = 32,
  parameter int                    MEM_DEPTH   = 256,
  parameter int                    RD_LATENCY  = 1,
  parameter bit                    INIT_ZERO   = 1'b1,
  parameter logic [DATA_WIDTH-1:0] ERR_PATTERN = 32'hDEADBEEF
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    data_req_i,
  input  logic [ADDR_WIDTH-1:0]   data_add_i,
  input  logic                    data_wen_i,
  input  logic [DATA_WIDTH-1:0]   data_wdata_i,
  input  logic [DATA_WIDTH/8-1:0] data_be_i,
  output logic                    data_gnt_o,
  output logic                    data_r_valid_o,
  output logic [DATA_WIDTH-1:0]   data_r_rdata_o,
  output logic [31:0]             ADDRA_o,
  output logic [DATA_WIDTH-1:0]   DINA_o,
  input  logic [DATA_WIDTH-1:0]   DOUTA_i,
  output logic                    ENA_o,
  output logic [DATA_WIDTH/8-1:0] WEA_o,
  output logic                    init_done_o,
`ifdef TCDM_BRIDGE_STATS_EN
  output logic [15:0]             rd_cnt_o,
  output logic [15:0]             wr_cnt_o,
  output logic [15:0]             err_cnt_o,
`endif
  output logic                    err_o
);

  localparam int          BE_WIDTH  = DATA_WIDTH / 8;
  localparam int          OFFS      = (BE_WIDTH > 1) ? $clog2(BE_WIDTH) : 0;
  localparam int          CNT_W     = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;
  localparam logic [31:0] MEM_BYTES = 32'(MEM_DEPTH * BE_WIDTH);

  // ST_RST holds every output at zero for the cycle after reset is sampled.
  typedef enum logic [1:0] {ST_RST, ST_INIT, ST_RUN} state_e;

  state_e                  state_q, state_d;
  logic [CNT_W-1:0]        init_cnt_q, init_cnt_d;
  logic                    init_done_q, init_done_d;
  logic                    err_q, err_d;
  logic [31:0]             addra_q, addra_d;
  logic [DATA_WIDTH-1:0]   dina_q, dina_d;
  logic [RD_LATENCY-1:0]   vld_q, vld_d, load_q, load_d, oor_q, oor_d;

  logic                    accept;
  logic                    req_oor;
  logic [31:0]             add_ext;
  logic [31:0]             word_addr;

  always_comb begin
    add_ext   = 32'(data_add_i);
    word_addr = add_ext >> OFFS;
    req_oor   = (add_ext >= MEM_BYTES);
    accept    = (state_q == ST_RUN) && data_req_i;
  end

  always_comb begin
    state_d    = state_q;
    init_cnt_d = init_cnt_q;
    case (state_q)
      ST_RST:  state_d = INIT_ZERO ? ST_INIT : ST_RUN;
      ST_INIT: begin
        init_cnt_d = init_cnt_q + 1'b1;
        if (init_cnt_q == CNT_W'(MEM_DEPTH - 1)) state_d = ST_RUN;
      end
      default: state_d = ST_RUN;
    endcase
    init_done_d = init_done_q | (state_d == ST_RUN);
  end

  // BRAM port: fill writes during INIT, accepted requests in RUN, otherwise address/data hold.
  always_comb begin
    data_gnt_o = accept;
    ENA_o      = 1'b0;
    WEA_o      = '0;
    ADDRA_o    = addra_q;
    DINA_o     = dina_q;
    if (state_q == ST_INIT) begin
      ENA_o   = 1'b1;
      WEA_o   = '1;
      ADDRA_o = 32'(init_cnt_q);
      DINA_o  = '0;
    end else if (accept) begin
      ADDRA_o = word_addr;
      DINA_o  = data_wdata_i;
      if (!req_oor) begin
        ENA_o = 1'b1;
        WEA_o = data_wen_i ? '0 : data_be_i;
      end
    end
    addra_d = ADDRA_o;
    dina_d  = DINA_o;
    err_d   = err_q | (accept & req_oor);
  end

  // Stage i holds the request accepted i+1 cycles ago; the last stage is the response cycle.
  always_comb begin
    vld_d     = '0;
    load_d    = '0;
    oor_d     = '0;
    vld_d[0]  = accept;
    load_d[0] = accept & data_wen_i;
    oor_d[0]  = accept & req_oor;
    for (int i = 1; i < RD_LATENCY; i++) begin
      vld_d[i]  = vld_q[i-1];
      load_d[i] = load_q[i-1];
      oor_d[i]  = oor_q[i-1];
    end
  end

  always_comb begin
    data_r_valid_o = vld_q[RD_LATENCY-1];
    data_r_rdata_o = '0;
    if (vld_q[RD_LATENCY-1] && load_q[RD_LATENCY-1]) begin
      data_r_rdata_o = oor_q[RD_LATENCY-1] ? ERR_PATTERN : DOUTA_i;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_RST;
      init_cnt_q  <= '0;
      init_done_q <= 1'b0;
      err_q       <= 1'b0;
      addra_q     <= '0;
      dina_q      <= '0;
      vld_q       <= '0;
      load_q      <= '0;
      oor_q       <= '0;
    end else begin
      state_q     <= state_d;
      init_cnt_q  <= init_cnt_d;
      init_done_q <= init_done_d;
      err_q       <= err_d;
      addra_q     <= addra_d;
      dina_q      <= dina_d;
      vld_q       <= vld_d;
      load_q      <= load_d;
      oor_q       <= oor_d;
    end
  end

  assign init_done_o = init_done_q;
  assign err_o       = err_q;

`ifdef TCDM_BRIDGE_STATS_EN
  logic [15:0] rd_cnt_q, rd_cnt_d, wr_cnt_q, wr_cnt_d, err_cnt_q, err_cnt_d;

  always_comb begin
    rd_cnt_d  = rd_cnt_q;
    wr_cnt_d  = wr_cnt_q;
    err_cnt_d = err_cnt_q;
    if (accept) begin
      if (data_wen_i && (rd_cnt_q != 16'hFFFF)) rd_cnt_d = rd_cnt_q + 16'd1;
      if (!data_wen_i && (wr_cnt_q != 16'hFFFF)) wr_cnt_d = wr_cnt_q + 16'd1;
      if (req_oor && (err_cnt_q != 16'hFFFF)) err_cnt_d = err_cnt_q + 16'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_cnt_q  <= '0;
      wr_cnt_q  <= '0;
      err_cnt_q <= '0;
    end else begin
      rd_cnt_q  <= rd_cnt_d;
      wr_cnt_q  <= wr_cnt_d;
      err_cnt_q <= err_cnt_d;
    end
  end

  assign rd_cnt_o  = rd_cnt_q;
  assign wr_cnt_o  = wr_cnt_q;
  assign err_cnt_o = err_cnt_q;
`endif

endmodule

// File: tb/tb_tcdm_bram_pipe_bridge.sv
// Bench for tcdm_bram_pipe_bridge: behavioural BRAM, word-array reference memory and an expected
// response queue keyed by due cycle; directed cases followed by random traffic.
module tb_tcdm_bram_pipe_bridge;

  localparam int AW        = 11;
  localparam int DW        = 32;
  localparam int DEPTH     = 256;
  localparam int LAT       = 2;
  localparam int MEM_BYTES = DEPTH * 4;
  localparam logic [31:0] ERR_PAT = 32'hDEADBEEF;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic          req_i = 1'b0;
  logic [AW-1:0] add_i = '0;
  logic          wen_i = 1'b1;
  logic [DW-1:0] wdata_i = '0;
  logic [3:0]    be_i = '0;
  logic          gnt, rvld, ena, init_done, err;
  logic [DW-1:0] rdata, dina, douta;
  logic [31:0]   addra;
  logic [3:0]    wea;
`ifdef TCDM_BRIDGE_STATS_EN
  logic [15:0]   rd_cnt, wr_cnt, err_cnt;
`endif

  tcdm_bram_pipe_bridge #(
    .ADDR_WIDTH (AW),
    .DATA_WIDTH (DW),
    .MEM_DEPTH  (DEPTH),
    .RD_LATENCY (LAT),
    .INIT_ZERO  (1'b1),
    .ERR_PATTERN(ERR_PAT)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .data_req_i    (req_i),
    .data_add_i    (add_i),
    .data_wen_i    (wen_i),
    .data_wdata_i  (wdata_i),
    .data_be_i     (be_i),
    .data_gnt_o    (gnt),
    .data_r_valid_o(rvld),
    .data_r_rdata_o(rdata),
    .ADDRA_o       (addra),
    .DINA_o        (dina),
    .DOUTA_i       (douta),
    .ENA_o         (ena),
    .WEA_o         (wea),
    .init_done_o   (init_done),
`ifdef TCDM_BRIDGE_STATS_EN
    .rd_cnt_o      (rd_cnt),
    .wr_cnt_o      (wr_cnt),
    .err_cnt_o     (err_cnt),
`endif
    .err_o         (err)
  );

  // ---------------- behavioural BRAM (starts full of garbage) ----------------
  logic [DW-1:0] bram [DEPTH];
  logic [DW-1:0] rd_pipe [LAT];
  logic          seeded = 1'b0;

  always @(posedge clk) begin
    if (!seeded) begin
      for (int i = 0; i < DEPTH; i++) bram[i] <= $urandom;
      seeded <= 1'b1;
    end else if (ena && (addra < 32'(DEPTH))) begin
      rd_pipe[0] <= bram[addra[7:0]];
      for (int b = 0; b < 4; b++)
        if (wea[b]) bram[addra[7:0]][8*b +: 8] <= dina[8*b +: 8];
    end else begin
      rd_pipe[0] <= 32'hBAD0BAD0;
    end
    for (int i = 1; i < LAT; i++) rd_pipe[i] <= rd_pipe[i-1];
  end
  assign douta = rd_pipe[LAT-1];

  // ---------------- reference model / scoreboard ----------------
  logic [DW-1:0] gold [DEPTH];
  logic [DW-1:0] exp_q [$];
  int            due_q [$];
  bit            err_exp = 1'b0;
  bit            hold_ok = 1'b0;
  logic [31:0]   last_addra = '0;
  logic [DW-1:0] last_dina = '0;
  int            rd_n = 0, wr_n = 0, er_n = 0;

  int vectors = 0;
  int miscompares = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic do_reset();
    rst   = 1'b1;
    req_i = 1'b1;
    repeat (2) @(negedge clk);
    chk("rst_gnt", 32'(gnt), 0);
    chk("rst_rvld", 32'(rvld), 0);
    chk("rst_rdata", rdata, 0);
    chk("rst_ena", 32'(ena), 0);
    chk("rst_wea", 32'(wea), 0);
    chk("rst_addra", addra, 0);
    chk("rst_dina", dina, 0);
    chk("rst_done", 32'(init_done), 0);
    chk("rst_err", 32'(err), 0);
`ifdef TCDM_BRIDGE_STATS_EN
    chk("rst_rdcnt", 32'(rd_cnt), 0);
    chk("rst_wrcnt", 32'(wr_cnt), 0);
    chk("rst_errcnt", 32'(err_cnt), 0);
`endif
    rst   = 1'b0;
    req_i = 1'b0;
    exp_q.delete();
    due_q.delete();
    err_exp = 1'b0;
    hold_ok = 1'b0;
    rd_n = 0; wr_n = 0; er_n = 0;
  endtask

  // Holds a load request during the fill; gnt must stay low until init_done.
  task automatic run_init(input int stop_at, output bit aborted);
    int fill;
    int last_wr;
    bit done;
    fill = 0; last_wr = -10; done = 1'b0; aborted = 1'b0;
    req_i = 1'b1; wen_i = 1'b1; add_i = '0;
    for (int k = 0; k < 400 && !done && !aborted; k++) begin
      @(negedge clk);
      if (init_done) begin
        done  = 1'b1;
        req_i = 1'b0;
      end else begin
        chk("init_gnt", 32'(gnt), 0);
        chk("init_rvld", 32'(rvld), 0);
        if (ena) begin
          chk("init_addra", addra, 32'(fill));
          chk("init_wea", 32'(wea), 32'hF);
          chk("init_dina", dina, 0);
          if (fill == stop_at) aborted = 1'b1;
          else begin
            last_wr = cyc;
            fill++;
          end
        end
      end
    end
    req_i = 1'b0;
    if (!aborted) begin
      chk("init_fills", 32'(fill), 32'(DEPTH));
      chk("init_done", 32'(init_done), 1);
      chk("init_done_lat", 32'(cyc - last_wr), 1);
      for (int i = 0; i < DEPTH; i++) gold[i] = '0;
      hold_ok    = 1'b1;
      last_addra = 32'(DEPTH - 1);
      last_dina  = '0;
    end
  endtask

  // One RUN-mode cycle: drive, check combinational/registered outputs, then update the model.
  task automatic step(input logic req, input logic [AW-1:0] add, input logic wen,
                      input logic [DW-1:0] wd, input logic [3:0] be);
    bit oor;
    int w;
    logic [DW-1:0] e;
    @(negedge clk);
    req_i = req; add_i = add; wen_i = wen; wdata_i = wd; be_i = be;
    #1;
    oor = (int'(add) >= MEM_BYTES);
    w   = int'(add) / 4;
    chk("gnt", 32'(gnt), 32'(req));
    if (req && !oor) begin
      chk("ena", 32'(ena), 1);
      chk("wea", 32'(wea), wen ? 32'h0 : 32'(be));
      chk("addra", addra, 32'(w));
      chk("dina", dina, wd);
      hold_ok = 1'b1; last_addra = 32'(w); last_dina = wd;
    end else if (req) begin
      chk("oor_ena", 32'(ena), 0);
      chk("oor_wea", 32'(wea), 0);
      hold_ok = 1'b0;
    end else begin
      chk("idle_ena", 32'(ena), 0);
      chk("idle_wea", 32'(wea), 0);
      if (hold_ok) begin
        chk("hold_addra", addra, last_addra);
        chk("hold_dina", dina, last_dina);
      end
    end
    if (due_q.size() > 0 && due_q[0] == cyc) begin
      chk("rvld", 32'(rvld), 1);
      chk("rdata", rdata, exp_q.pop_front());
      void'(due_q.pop_front());
    end else begin
      chk("rvld_idle", 32'(rvld), 0);
      chk("rdata_idle", rdata, 0);
    end
    chk("err", 32'(err), 32'(err_exp));
`ifdef TCDM_BRIDGE_STATS_EN
    chk("rd_cnt", 32'(rd_cnt), 32'(rd_n));
    chk("wr_cnt", 32'(wr_cnt), 32'(wr_n));
    chk("err_cnt", 32'(err_cnt), 32'(er_n));
`endif
    if (req) begin
      due_q.push_back(cyc + LAT);
      if (!wen)     e = '0;
      else if (oor) e = ERR_PAT;
      else          e = gold[w];
      exp_q.push_back(e);
      if (!wen && !oor)
        for (int b = 0; b < 4; b++) if (be[b]) gold[w][8*b +: 8] = wd[8*b +: 8];
      if (wen) rd_n++; else wr_n++;
      if (oor) begin er_n++; err_exp = 1'b1; end
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, '0, 1'b1, '0, '0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    bit ab;
    do_reset();
    run_init(100, ab);
    chk("fill_reached_100", 32'(ab), 1);
    do_reset();
    run_init(-1, ab);

    step(1'b1, 11'h3FC, 1'b1, '0, '0);
    idle(LAT + 1);

    step(1'b1, 11'h010, 1'b0, 32'hA5A5_0001, 4'hF);
    step(1'b1, 11'h010, 1'b1, '0, '0);
    idle(LAT + 1);

    step(1'b1, 11'h020, 1'b0, 32'hFFFF_FFFF, 4'hF);
    step(1'b1, 11'h020, 1'b0, 32'h1122_3344, 4'b0101);
    step(1'b1, 11'h022, 1'b1, '0, '0);
    idle(LAT + 1);

    for (int i = 0; i < 16; i++) step(1'b1, AW'(i * 4), 1'b0, 32'(i), 4'hF);
    for (int i = 0; i < 16; i++) step(1'b1, AW'(i * 4), 1'b1, '0, '0);
    idle(LAT + 1);

    step(1'b1, 11'h400, 1'b1, '0, '0);
    idle(LAT + 1);
    step(1'b1, 11'h7FC, 1'b0, 32'h1234_5678, 4'hF);
    step(1'b1, 11'h030, 1'b0, 32'h5555_AAAA, 4'h0);
    step(1'b1, 11'h030, 1'b1, '0, '0);
    step(1'b1, 11'h3FF, 1'b1, '0, '0);
    idle(LAT + 1);

    for (int i = 0; i < 400; i++) begin
      logic [AW-1:0] a;
      if ($urandom_range(0, 7) == 0) a = AW'($urandom_range(MEM_BYTES, 2047));
      else                           a = AW'($urandom_range(0, MEM_BYTES - 1));
      step(1'($urandom_range(0, 3) != 0), a, 1'($urandom_range(0, 1)),
           32'($urandom), 4'($urandom_range(0, 15)));
    end
    idle(LAT + 2);
    chk("queue_drained", 32'(exp_q.size()), 0);

    step(1'b1, 11'h040, 1'b1, '0, '0);
    do_reset();
    run_init(-1, ab);
    idle(LAT + 1);
    step(1'b1, 11'h010, 1'b1, '0, '0);
    idle(LAT + 1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL timeout: simulation exceeded its time budget at cycle %0d", cyc);
    $fatal(1);
  end

endmodule
